// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared FSM state type, default widths and output-queue
// helpers for the fifo_reader slice.
package fifo_reader_pkg;

    localparam int DEFAULT_PIX_WIDTH  = 16;
    localparam int DEFAULT_MEM_LENGTH = 8;
    localparam int QUEUE_DEPTH        = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_e;

    // Free entries left in the 2-deep output queue for a given occupancy.
    function automatic logic [1:0] slots_free(input logic [1:0] occupancy);
        return 2'(QUEUE_DEPTH) - occupancy;
    endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// fifo_reader_skid: 2-entry first-in first-out output queue. The head entry
// drives the downstream data port; the tail holds the second pixel.
module fifo_reader_skid
    import fifo_reader_pkg::*;
#(
    parameter int PIX_WIDTH = DEFAULT_PIX_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [PIX_WIDTH-1:0] push_data,
    input  logic                 pop_ready,
    output logic [PIX_WIDTH-1:0] head_data,
    output logic                 head_valid,
    output logic [1:0]           occupancy
);

    logic [PIX_WIDTH-1:0] head_q, head_d;
    logic [PIX_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]           occ_q, occ_d;
    logic                 pop;
    logic                 push_ok;

    // Next-state of the two entries; a push into a full queue is only taken
    // when a pop frees the head in the same cycle.
    always_comb begin
        pop     = pop_ready && (occ_q != 2'd0);
        push_ok = push && ((occ_q < 2'd2) || pop);
        head_d  = head_q;
        tail_d  = tail_q;
        occ_d   = occ_q;
        case (occ_q)
            2'd0: begin
                if (push_ok) begin
                    head_d = push_data;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                case ({push_ok, pop})
                    2'b11: head_d = push_data;
                    2'b10: begin
                        tail_d = push_data;
                        occ_d  = 2'd2;
                    end
                    2'b01: occ_d = 2'd0;
                    default: ;
                endcase
            end
            default: begin
                if (pop) begin
                    head_d = tail_q;
                    if (push_ok) begin
                        tail_d = push_data;
                    end else begin
                        occ_d = 2'd1;
                    end
                end
            end
        endcase
    end

    // Queue registers; reset empties the queue and zeroes the visible head.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign head_data  = head_q;
    assign head_valid = (occ_q != 2'd0);
    assign occupancy  = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: pulls pixels from an upstream FIFO with a req/ack handshake
// (one request outstanding at a time) and hands them downstream through a
// 2-entry valid/ready queue. Build option FIFO_READER_TIMEOUT_EN adds a
// WAIT_ACK watchdog with a sticky timeout flag.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int PIX_WIDTH      = DEFAULT_PIX_WIDTH,
    parameter int MEM_LENGTH     = DEFAULT_MEM_LENGTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [MEM_LENGTH-1:0] fill,
    input  logic [PIX_WIDTH-1:0]  pix_in,
    input  logic                  ack_in,
    output logic                  req_out,
    output logic [PIX_WIDTH-1:0]  pix_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [15:0]           pix_count,
    output logic                  timeout
);

    if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("fifo_reader: TIMEOUT_CYCLES must be within 2..65535");
    end

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic [15:0] count_q, count_d;
    logic        capture;
    logic [1:0]  occupancy;

`ifdef FIFO_READER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        timeout_q, timeout_d;
`endif

    fifo_reader_skid #(
        .PIX_WIDTH(PIX_WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (capture),
        .push_data (pix_in),
        .pop_ready (ready_in),
        .head_data (pix_out),
        .head_valid(valid_out),
        .occupancy (occupancy)
    );

    // Request FSM next state; acks outside a request are dropped, and the
    // request line is a registered copy of "next state is not IDLE".
    always_comb begin
        capture = ack_in && (state_q != ST_IDLE);
        state_d = state_q;
`ifdef FIFO_READER_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if ((fill != '0) && (slots_free(occupancy) >= 2'd1)) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = capture ? ST_IDLE : ST_WAIT_ACK;
`ifdef FIFO_READER_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            ST_WAIT_ACK: begin
                if (capture) begin
                    state_d = ST_IDLE;
                end
`ifdef FIFO_READER_TIMEOUT_EN
                else if (wait_cnt_q == TIMEOUT_LAST) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        req_d   = (state_d != ST_IDLE);
        count_d = count_q + 16'(valid_out && ready_in);
    end

    // FSM, request output and delivered-pixel counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            count_q <= '0;
`ifdef FIFO_READER_TIMEOUT_EN
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            count_q <= count_d;
`ifdef FIFO_READER_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign req_out   = req_q;
    assign pix_count = count_q;
`ifdef FIFO_READER_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: scoreboard bench. The driver plays the upstream FIFO and
// the downstream consumer; every pixel it hands over on an ack is queued as
// the expected output, and an independent monitor checks the DUT outputs.
`timescale 1ns/1ps
module tb_fifo_reader;

    localparam int PW = 16;
    localparam int ML = 8;
    localparam int TO = 4;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic [ML-1:0] fill     = '0;
    logic [PW-1:0] pix_in   = '0;
    logic          ack_in   = 1'b0;
    logic          ready_in = 1'b0;
    logic          req_out;
    logic [PW-1:0] pix_out;
    logic          valid_out;
    logic [15:0]   pix_count;
    logic          timeout;

    fifo_reader #(
        .PIX_WIDTH     (PW),
        .MEM_LENGTH    (ML),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .fill     (fill),
        .pix_in   (pix_in),
        .ack_in   (ack_in),
        .req_out  (req_out),
        .pix_out  (pix_out),
        .valid_out(valid_out),
        .ready_in (ready_in),
        .pix_count(pix_count),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [PW-1:0] src_q[$];
    logic [PW-1:0] exp_q[$];
    bit            pend = 1'b0;
    bit            auto_ack = 1'b0;
    bit            ready_with_ack = 1'b0;
    bit            stray = 1'b0;
    logic [PW-1:0] stray_pix = '0;
    int            acks_left = 0;
    int            min_delay = 0;
    int            max_delay = 0;
    int            ack_delay = 0;
    int            req_age = 0;
    int            delivered = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: upstream FIFO answers requests after ack_delay cycles.
    task automatic step();
        @(posedge clk);
        #1;
        ack_in = 1'b0;
        pend   = 1'b0;
        if (!reset && auto_ack && req_out && acks_left > 0 && src_q.size() != 0) begin
            if (req_age >= ack_delay) begin
                ack_in = 1'b1;
                pix_in = src_q.pop_front();
                exp_q.push_back(pix_in);
                pend      = 1'b1;
                acks_left = acks_left - 1;
                req_age   = 0;
                ack_delay = int'($urandom_range(max_delay, min_delay));
            end else begin
                req_age++;
            end
        end else begin
            req_age = 0;
        end
        if (stray) begin
            ack_in = 1'b1;
            pix_in = stray_pix;
        end
        if (ready_with_ack) ready_in = ack_in;
        fill = ML'(src_q.size());
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        auto_ack       = 1'b0;
        ready_with_ack = 1'b0;
        ready_in       = 1'b0;
        src_q.delete();
        exp_q.delete();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || src_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(exp_q.size() + src_q.size()), 32'd0);
        step();
    endtask

    task automatic set_delay(input int lo, input int hi);
        min_delay = lo;
        max_delay = hi;
        ack_delay = int'($urandom_range(hi, lo));
    endtask

    // Monitor: compares outputs against the expected pixel queue each cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                delivered = 0;
            end else begin
                int visible;
                visible = exp_q.size() - (pend ? 1 : 0);
                check("valid_out", 32'(valid_out), 32'(visible != 0));
                check("pix_count", 32'(pix_count), 32'(16'(delivered)));
                if (visible == 2) check("req_when_full", 32'(req_out), 32'd0);
                if (visible > 0) begin
                    check("pix_out", 32'(pix_out), 32'(exp_q[0]));
                    if (ready_in) begin
                        void'(exp_q.pop_front());
                        delivered++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int gen;

        // Reset values
        do_reset();
        check("rst_req", 32'(req_out), 32'd0);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_pix_out", 32'(pix_out), 32'd0);
        check("rst_count", 32'(pix_count), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);

        // Three pixels, ack two cycles after each request rise
        src_q = '{16'h1111, 16'h2222, 16'h3333};
        ready_in = 1'b1; auto_ack = 1'b1; acks_left = 100; set_delay(2, 2);
        drain("drain_basic", 60);
        for (int i = 0; i < 8; i++) begin
            step();
            check("req_low_empty", 32'(req_out), 32'd0);
        end
        check("count_basic", 32'(pix_count), 32'd3);

        // Backpressure: only two pixels may be fetched
        do_reset();
        for (int i = 0; i < 5; i++) src_q.push_back(16'(16'h2400 + i));
        auto_ack = 1'b1; acks_left = 100; set_delay(0, 3);
        for (int i = 0; i < 30; i++) step();
        check("bp_acks", 32'(src_q.size()), 32'd3);
        check("bp_valid", 32'(valid_out), 32'd1);
        check("bp_head", 32'(pix_out), 32'h2400);
        check("bp_req", 32'(req_out), 32'd0);
        ready_in = 1'b1;
        drain("drain_bp", 80);
        check("count_bp", 32'(pix_count), 32'd5);

        // Ack and pop in the same cycle keep the queue at one entry
        do_reset();
        src_q = '{16'hA000, 16'hA001, 16'hA002};
        ready_with_ack = 1'b1; auto_ack = 1'b1; acks_left = 100; set_delay(1, 1);
        n = 0;
        while (src_q.size() != 0 && n < 40) begin step(); n++; end
        check("same_cycle_acks", 32'(src_q.size()), 32'd0);
        ready_with_ack = 1'b0;
        step();
        check("same_cycle_valid", 32'(valid_out), 32'd1);
        check("same_cycle_head", 32'(pix_out), 32'hA002);
        ready_in = 1'b1;
        drain("drain_same", 20);
        check("count_same", 32'(pix_count), 32'd3);

        // Stray ack while idle is discarded
        do_reset();
        ready_in = 1'b1;
        step(); step();
        stray = 1'b1; stray_pix = 16'hDEAD;
        step();
        stray = 1'b0;
        check("stray_req_low", 32'(req_out), 32'd0);
        for (int i = 0; i < 6; i++) step();
        check("stray_count", 32'(pix_count), 32'd0);
        src_q = '{16'h0B0B};
        auto_ack = 1'b1; acks_left = 100; set_delay(0, 1);
        drain("drain_stray", 20);
        check("count_stray", 32'(pix_count), 32'd1);

        // Random traffic
        do_reset();
        auto_ack = 1'b1; acks_left = 1000000; set_delay(0, 3);
        gen = 0;
        for (int i = 0; i < 500; i++) begin
            if (src_q.size() < 6 && $urandom_range(2, 0) == 0) begin
                src_q.push_back(16'($urandom()));
                gen++;
            end
            ready_in = ($urandom_range(3, 0) != 0);
            step();
        end
        ready_in = 1'b1;
        drain("drain_random", 200);
        check("count_random", 32'(pix_count), 32'(16'(gen)));

        // Watchdog: request with no ack
        do_reset();
        src_q = '{16'h7E57};
        n = 0;
        step();
        while (!req_out && n < 10) begin step(); n++; end
        check("to_req_rise", 32'(req_out), 32'd1);
`ifdef FIFO_READER_TIMEOUT_EN
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 4) begin
                check("to_before_req", 32'(req_out), 32'd1);
                check("to_before_flag", 32'(timeout), 32'd0);
            end
        end
        check("to_req_low", 32'(req_out), 32'd0);
        check("to_flag", 32'(timeout), 32'd1);
        for (int i = 0; i < 3; i++) step();
        check("to_sticky", 32'(timeout), 32'd1);
`else
        for (int k = 1; k <= 20; k++) begin
            step();
            check("noto_req_high", 32'(req_out), 32'd1);
            check("noto_flag", 32'(timeout), 32'd0);
        end
        auto_ack = 1'b1; acks_left = 100; set_delay(0, 0);
        ready_in = 1'b1;
        drain("drain_noto", 20);
`endif

        // Reset pulsed during WAIT_ACK, late ack ignored
        do_reset();
        src_q = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
        ready_in = 1'b1; auto_ack = 1'b1; acks_left = 2; set_delay(0, 2);
        n = 0;
        while ((acks_left != 0 || exp_q.size() != 0) && n < 40) begin step(); n++; end
        check("rst_pre_count", 32'(pix_count), 32'd2);
        ready_in = 1'b0; acks_left = 1;
        n = 0;
        while (acks_left != 0 && n < 20) begin step(); n++; end
        step(); step();
        check("rst_pre_valid", 32'(valid_out), 32'd1);
        n = 0;
        while (!req_out && n < 10) begin step(); n++; end
        step();
        check("rst_in_wait", 32'(req_out), 32'd1);
        reset = 1'b1;
        src_q.delete();
        exp_q.delete();
        stray = 1'b1; stray_pix = 16'hBEEF;
        step();
        stray = 1'b0;
        reset = 1'b0;
        check("rst_mid_req", 32'(req_out), 32'd0);
        check("rst_mid_valid", 32'(valid_out), 32'd0);
        check("rst_mid_pix", 32'(pix_out), 32'd0);
        check("rst_mid_count", 32'(pix_count), 32'd0);
        check("rst_mid_timeout", 32'(timeout), 32'd0);
        for (int i = 0; i < 8; i++) step();
        check("late_ack_valid", 32'(valid_out), 32'd0);
        check("late_ack_count", 32'(pix_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
